posit_mult_err_monitor: RTL and testbench

- Synthesizable result checker that sits directly downstream of posit_mult (N=8, es=3).
- Consumes each multiplier result alongside a golden result and produces the per-sample absolute difference.
- Accumulates run statistics: sample count, mismatch count, max diff, diff sum, first-error index.
- Replaces the off-line diff file for on-chip and long-run regression; statistics are held for readout after a run.

---
 rtl/posit_pkg.sv | 9 +
 rtl/posit_absdiff.sv | 10 +
 rtl/posit_mult_err_monitor.sv | 98 +++++++++
 tb/tb_posit_mult_err_monitor.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared state encoding, posit constants and default widths for posit checkers.
package posit_pkg;
  localparam int N_DEF = 8;
  localparam int CNT_W_DEF = 17;
  localparam int SUM_W_DEF = CNT_W_DEF + N_DEF;
  localparam logic [N_DEF-1:0] POSIT_ZERO = '0;
  localparam logic [N_DEF-1:0] POSIT_NAR = {1'b1, {(N_DEF-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/posit_absdiff.sv
// posit_absdiff: unsigned magnitude difference of two raw N-bit posit patterns.
module posit_absdiff #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d
);
  assign d = (a > b) ? a - b : b - a;
endmodule

// File: rtl/posit_mult_err_monitor.sv
// posit_mult_err_monitor: two-stage diff pipeline against a golden result with saturating run statistics.
module posit_mult_err_monitor
  import posit_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [N-1:0]     dut_out,
  input  logic [N-1:0]     ref_out,
  output logic             diff_valid,
  output logic [N-1:0]     diff,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     max_diff,
  output logic [SUM_W-1:0] diff_sum,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);
  state_t state;
  logic a_vld, accept;
  logic [N-1:0] a_dut, a_ref, d;
  logic [CNT_W-1:0] a_idx;
  logic [SUM_W:0] sum_ext;
  assign accept = (state == RUN) && in_valid;
  assign sum_ext = {1'b0, diff_sum} + {{(SUM_W+1-N){1'b0}}, d};
  posit_absdiff #(.N(N)) u_absdiff (.a(a_ref), .b(a_dut), .d(d));
  // Stage B commits statistics on the same edge it loads diff, so an empty stage A means the run is final.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      a_vld <= 1'b0;
      a_dut <= '0;
      a_ref <= '0;
      a_idx <= '0;
      diff_valid <= 1'b0;
      diff <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      max_diff <= '0;
      diff_sum <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
        end
        RUN: if (stop) state <= DRAIN;
        DRAIN: if (!a_vld) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      a_vld <= accept;
      if (accept) begin
        a_dut <= dut_out;
        a_ref <= ref_out;
        a_idx <= sample_cnt;
        sample_cnt <= (&sample_cnt) ? sample_cnt : sample_cnt + 1'b1;
      end
      diff_valid <= a_vld;
      if (a_vld) begin
        diff <= d;
        max_diff <= (d > max_diff) ? d : max_diff;
        diff_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (d != '0) begin
          err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
          if (!first_err_vld) begin
            first_err_idx <= a_idx;
            first_err_vld <= 1'b1;
          end
        end
      end
      if (state == IDLE && start) begin
        sample_cnt <= '0;
        err_cnt <= '0;
        max_diff <= '0;
        diff_sum <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_posit_mult_err_monitor.sv
// tb_posit_mult_err_monitor: randomized and directed checks against a list-based reference model.
module tb_posit_mult_err_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [7:0] dut_out = '0, ref_out = '0;
  logic diff_valid, busy, done, first_err_vld;
  logic [7:0] diff, max_diff;
  logic [16:0] sample_cnt, err_cnt, first_err_idx;
  logic [24:0] diff_sum;
  logic s_diff_valid, s_busy, s_done, s_first_err_vld;
  logic [7:0] s_diff, s_max_diff;
  logic [2:0] s_sample_cnt, s_err_cnt, s_first_err_idx;
  logic [10:0] s_diff_sum;
  int checks = 0, errors = 0;
  logic q_v[$];
  logic [7:0] q_dut[$], q_ref[$];
  logic obs_dv[$];
  logic [7:0] obs_diff[$];
  int stop_cyc, done_cyc, done_n;

  always #5 clk = ~clk;

  posit_mult_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .dut_out(dut_out), .ref_out(ref_out), .diff_valid(diff_valid), .diff(diff),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_diff(max_diff), .diff_sum(diff_sum), .first_err_idx(first_err_idx),
    .first_err_vld(first_err_vld)
  );

  posit_mult_err_monitor #(.N(8), .CNT_W(3), .SUM_W(11)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .dut_out(dut_out), .ref_out(ref_out), .diff_valid(s_diff_valid), .diff(s_diff),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .max_diff(s_max_diff), .diff_sum(s_diff_sum), .first_err_idx(s_first_err_idx),
    .first_err_vld(s_first_err_vld)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic v, input logic [7:0] du, input logic [7:0] rf);
    start = s;
    stop = p;
    in_valid = v;
    dut_out = du;
    ref_out = rf;
    step();
  endtask

  task automatic add(input logic v, input logic [7:0] du, input logic [7:0] rf);
    q_v.push_back(v);
    q_dut.push_back(du);
    q_ref.push_back(rf);
  endtask

  task automatic clear_q();
    q_v.delete();
    q_dut.delete();
    q_ref.delete();
  endtask

  // Start a run, play the queued samples, stop (on the last sample or one cycle after), record outputs.
  task automatic run_seq(input logic stop_last);
    int n;
    n = q_v.size();
    obs_dv.delete();
    obs_diff.delete();
    done_n = 0;
    done_cyc = -1;
    stop_cyc = stop_last ? n - 1 : n;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < n + 6; c++) begin
      if (c < n) drive(1'b0, c == stop_cyc, q_v[c], q_dut[c], q_ref[c]);
      else drive(1'b0, c == stop_cyc, 1'b0, 8'h00, 8'h00);
      obs_dv.push_back(diff_valid);
      obs_diff.push_back(diff);
      if (done) begin
        done_n++;
        done_cyc = c;
      end
    end
  endtask

  function automatic int absd(input logic [7:0] a, input logic [7:0] b);
    int x;
    x = int'(a) - int'(b);
    return x < 0 ? -x : x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({diff_valid, diff, busy, done, sample_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %0h exp 0", {diff_valid, diff, busy, done, sample_cnt, err_cnt});
    end
    checks++;
    if ({max_diff, diff_sum, first_err_idx, first_err_vld} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %0h exp 0", {max_diff, diff_sum, first_err_idx, first_err_vld});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_exact_match();
    int nv;
    clear_q();
    for (int i = 0; i < 4; i++) add(1'b1, 8'h40, 8'h40);
    run_seq(1'b0);
    nv = 0;
    for (int c = 0; c < obs_dv.size(); c++) if (obs_dv[c]) begin
      nv++;
      checks++;
      if (obs_diff[c] !== 8'h00) begin
        errors++;
        $display("FAIL exact_diff: cycle %0d got %0h exp 0", c, obs_diff[c]);
      end
    end
    checks++;
    if (nv != 4) begin
      errors++;
      $display("FAIL exact_nvalid: got %0d exp 4", nv);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL exact_done: got %0d pulses exp 1", done_n);
    end
    checks++;
    if ({sample_cnt, err_cnt, max_diff, diff_sum, first_err_vld} !== {17'd4, 17'd0, 8'd0, 25'd0, 1'b0}) begin
      errors++;
      $display("FAIL exact_stats: cnt %0d err %0d max %0h sum %0d fv %0b exp 4 0 0 0 0", sample_cnt, err_cnt, max_diff, diff_sum, first_err_vld);
    end
  endtask

  task automatic test_mixed_errors();
    logic [7:0] exp_d[4];
    int k;
    exp_d = '{8'h00, 8'h01, 8'h08, 8'h80};
    clear_q();
    add(1'b1, 8'h40, 8'h40);
    add(1'b1, 8'h41, 8'h40);
    add(1'b1, 8'h30, 8'h38);
    add(1'b1, 8'h80, 8'h00);
    run_seq(1'b0);
    k = 0;
    for (int c = 0; c < obs_dv.size(); c++) if (obs_dv[c] && k < 4) begin
      checks++;
      if (obs_diff[c] !== exp_d[k]) begin
        errors++;
        $display("FAIL mixed_diff%0d: got %0h exp %0h", k, obs_diff[c], exp_d[k]);
      end
      k++;
    end
    checks++;
    if ({err_cnt, max_diff, diff_sum} !== {17'd3, 8'h80, 25'd137}) begin
      errors++;
      $display("FAIL mixed_stats: err %0d max %0h sum %0d exp 3 80 137", err_cnt, max_diff, diff_sum);
    end
    checks++;
    if ({first_err_vld, first_err_idx} !== {1'b1, 17'd1}) begin
      errors++;
      $display("FAIL mixed_first: vld %0b idx %0d exp 1 1", first_err_vld, first_err_idx);
    end
  endtask

  task automatic test_latency_gaps();
    clear_q();
    add(1'b1, 8'h20, 8'h25);
    add(1'b0, 8'h00, 8'h00);
    add(1'b1, 8'h7f, 8'h01);
    run_seq(1'b1);
    checks++;
    if ({obs_dv[0], obs_dv[1], obs_dv[2], obs_dv[3], obs_dv[4]} !== 5'b01010) begin
      errors++;
      $display("FAIL gaps_valid: got %b exp 01010", {obs_dv[0], obs_dv[1], obs_dv[2], obs_dv[3], obs_dv[4]});
    end
    checks++;
    if ({obs_diff[1], obs_diff[3]} !== {8'h05, 8'h7e}) begin
      errors++;
      $display("FAIL gaps_diff: got %0h %0h exp 5 7e", obs_diff[1], obs_diff[3]);
    end
    checks++;
    if (sample_cnt !== 17'd2) begin
      errors++;
      $display("FAIL gaps_cnt: got %0d exp 2", sample_cnt);
    end
    checks++;
    if (done_cyc != stop_cyc + 2 || done_n != 1) begin
      errors++;
      $display("FAIL gaps_done: at %0d (%0d pulses) exp %0d", done_cyc, done_n, stop_cyc + 2);
    end
  endtask

  task automatic test_saturation();
    clear_q();
    for (int i = 0; i < 10; i++) add(1'b1, 8'h00, 8'hff);
    run_seq(1'b0);
    checks++;
    if ({s_sample_cnt, s_err_cnt} !== {3'd7, 3'd7}) begin
      errors++;
      $display("FAIL sat_cnt: cnt %0d err %0d exp 7 7", s_sample_cnt, s_err_cnt);
    end
    checks++;
    if ({s_diff_sum, s_max_diff, s_first_err_idx} !== {11'd2047, 8'hff, 3'd0}) begin
      errors++;
      $display("FAIL sat_sum: sum %0d max %0h idx %0d exp 2047 ff 0", s_diff_sum, s_max_diff, s_first_err_idx);
    end
    checks++;
    if ({sample_cnt, err_cnt, diff_sum} !== {17'd10, 17'd10, 25'd2550}) begin
      errors++;
      $display("FAIL wide_cnt: cnt %0d err %0d sum %0d exp 10 10 2550", sample_cnt, err_cnt, diff_sum);
    end
  endtask

  task automatic test_collisions();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if ({busy, done, sample_cnt} !== {1'b1, 1'b0, 17'd0}) begin
      errors++;
      $display("FAIL coll_idle: busy %0b done %0b cnt %0d exp 1 0 0", busy, done, sample_cnt);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if ({busy, sample_cnt, err_cnt} !== {1'b1, 17'd1, 17'd1}) begin
      errors++;
      $display("FAIL coll_run_start: busy %0b cnt %0d err %0d exp 1 1 1", busy, sample_cnt, err_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++;
    if ({busy, done, sample_cnt} !== {1'b1, 1'b0, 17'd1}) begin
      errors++;
      $display("FAIL coll_run_both: busy %0b done %0b cnt %0d exp 1 0 1", busy, done, sample_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL coll_done: got %0b exp 1", done);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if ({busy, done, sample_cnt, err_cnt} !== {1'b0, 1'b0, 17'd1, 17'd1}) begin
      errors++;
      $display("FAIL coll_hold: busy %0b done %0b cnt %0d err %0d exp 0 0 1 1", busy, done, sample_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int bad;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h01, 8'h09);
    drive(1'b0, 1'b0, 1'b1, 8'h02, 8'h02);
    drive(1'b0, 1'b0, 1'b1, 8'h33, 8'h03);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({diff_valid, diff, busy, done, sample_cnt, err_cnt, max_diff, diff_sum, first_err_idx, first_err_vld} !== '0) begin
      errors++;
      $display("FAIL midrun_zero: got %0h exp 0", {diff_valid, diff, busy, done, sample_cnt, err_cnt, max_diff, diff_sum, first_err_idx, first_err_vld});
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h06);
      if (diff_valid || done || busy || sample_cnt != 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrun_quiet: %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_random();
    int n, e_cnt, e_err, e_max, e_sum, e_fidx, e_done, dd, bad;
    logic [7:0] a, b;
    logic acc;
    for (int r = 0; r < 4; r++) begin
      clear_q();
      n = $urandom_range(60, 20);
      for (int i = 0; i < n; i++) begin
        a = 8'($urandom);
        case ($urandom_range(4, 0))
          0, 1: b = a;
          2: b = ($urandom_range(1, 0) != 0) ? 8'h80 : 8'h00;
          default: b = 8'($urandom);
        endcase
        add($urandom_range(9, 0) < 7, a, b);
      end
      run_seq($urandom_range(1, 0) != 0);
      e_cnt = 0; e_err = 0; e_max = 0; e_sum = 0; e_fidx = -1; bad = 0;
      for (int c = 0; c < n + 5; c++) begin
        acc = c < n && c <= stop_cyc && q_v[c];
        if (obs_dv[c+1] !== acc) bad++;
        if (acc) begin
          dd = absd(q_ref[c], q_dut[c]);
          if (obs_diff[c+1] !== 8'(dd)) bad++;
          if (dd != 0 && e_fidx < 0) e_fidx = e_cnt;
          e_cnt++;
          if (dd != 0) e_err++;
          if (dd > e_max) e_max = dd;
          e_sum += dd;
        end
      end
      e_done = stop_cyc + ((stop_cyc < n && q_v[stop_cyc]) ? 2 : 1);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand%0d_stream: %0d mismatching cycles exp 0", r, bad);
      end
      checks++;
      if (done_n != 1 || done_cyc != e_done) begin
        errors++;
        $display("FAIL rand%0d_done: at %0d (%0d pulses) exp %0d", r, done_cyc, done_n, e_done);
      end
      checks++;
      if ({sample_cnt, err_cnt, max_diff, diff_sum} !== {17'(e_cnt), 17'(e_err), 8'(e_max), 25'(e_sum)}) begin
        errors++;
        $display("FAIL rand%0d_stats: cnt %0d err %0d max %0h sum %0d exp %0d %0d %0h %0d", r, sample_cnt, err_cnt, max_diff, diff_sum, e_cnt, e_err, e_max, e_sum);
      end
      checks++;
      if (first_err_vld !== (e_fidx >= 0) || (e_fidx >= 0 && first_err_idx !== 17'(e_fidx))) begin
        errors++;
        $display("FAIL rand%0d_first: vld %0b idx %0d exp idx %0d", r, first_err_vld, first_err_idx, e_fidx);
      end
      checks++;
      if ({s_sample_cnt, s_err_cnt, s_diff_sum} !== {3'(e_cnt > 7 ? 7 : e_cnt), 3'(e_err > 7 ? 7 : e_err), 11'(e_sum > 2047 ? 2047 : e_sum)}) begin
        errors++;
        $display("FAIL rand%0d_sat: cnt %0d err %0d sum %0d exp %0d %0d %0d", r, s_sample_cnt, s_err_cnt, s_diff_sum, e_cnt, e_err, e_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_mixed_errors();
    test_latency_gaps();
    test_saturation();
    test_collisions();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
